// File: rtl/rb_fetch.sv
// Read-back fetch: reads four consecutive result-RAM words
// and presents them as parallel operands OP1..OP4.
module rb_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int OP_W   = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reb,
  input  logic              ld,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ram_en,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataRAM,
  output logic [OP_W-1:0]   OP1,
  output logic [OP_W-1:0]   OP2,
  output logic [OP_W-1:0]   OP3,
  output logic [OP_W-1:0]   OP4,
  output logic              valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        iss_cnt;
  logic [1:0]        cap_cnt;
  logic              cap_en;
  logic [OP_W-1:0]   word;
  logic [OP_W-1:0]   buf_q [0:3];
  logic              accept;
  logic              unused_hi;

  assign word      = dataRAM[OP_W-1:0];
  assign unused_hi = ^dataRAM[DATA_W-1:OP_W];
  assign accept    = (state == IDLE) || (state == DONE);
  assign ram_en    = (state == ISSUE);
  assign address   = ptr;
  assign busy      = (state == ISSUE) || (state == DRAIN);
  assign valid     = (state == DONE);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (reb) nxt = ISSUE;
      ISSUE:   if (iss_cnt == 2'd3) nxt = DRAIN;
      DRAIN:   nxt = DONE;
      DONE:    nxt = reb ? ISSUE : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      iss_cnt <= '0;
      cap_cnt <= '0;
      cap_en  <= 1'b0;
      OP1     <= '0;
      OP2     <= '0;
      OP3     <= '0;
      OP4     <= '0;
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
    end else begin
      state  <= nxt;
      cap_en <= ram_en;
      if (accept && ld)
        ptr <= ld_addr;
      else if (state == ISSUE)
        ptr <= ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (accept)
        iss_cnt <= '0;
      else if (state == ISSUE)
        iss_cnt <= iss_cnt + 2'd1;
      if (cap_en) begin
        buf_q[cap_cnt] <= word;
        cap_cnt        <= cap_cnt + 2'd1;
      end
      // Last word bypasses the buffer so OPs are fresh while valid is high
      if (state == DRAIN) begin
        OP1 <= buf_q[0];
        OP2 <= buf_q[1];
        OP3 <= buf_q[2];
        OP4 <= word;
      end
    end
  end

endmodule

// File: tb/tb_rb_fetch.sv
// Directed bench for rb_fetch with a one-cycle-latency RAM model.
module tb_rb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        reb;
  logic        ld;
  logic [7:0]  ld_addr;
  logic        ram_en;
  logic [7:0]  address;
  logic [31:0] dataRAM;
  logic [17:0] OP1, OP2, OP3, OP4;
  logic        valid;
  logic        busy;

  logic [31:0] mem [0:255];
  logic [17:0] prev [0:3];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_en) dataRAM <= mem[address];

  rb_fetch dut (
    .clk(clk), .rst(rst), .reb(reb), .ld(ld),
    .ld_addr(ld_addr), .ram_en(ram_en),
    .address(address), .dataRAM(dataRAM),
    .OP1(OP1), .OP2(OP2), .OP3(OP3), .OP4(OP4),
    .valid(valid), .busy(busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ops(input string tag,
                         input logic [17:0] e1, e2, e3, e4);
    chk({tag, ".op1"}, {14'd0, OP1}, {14'd0, e1});
    chk({tag, ".op2"}, {14'd0, OP2}, {14'd0, e2});
    chk({tag, ".op3"}, {14'd0, OP3}, {14'd0, e3});
    chk({tag, ".op4"}, {14'd0, OP4}, {14'd0, e4});
  endtask

  // Called in an IDLE or DONE cycle; returns in the DONE cycle.
  task automatic fetch(input string tag,
                       input logic [7:0] a0,
                       input bit do_ld,
                       input bit noise,
                       input logic [17:0] e1, e2, e3, e4);
    reb = 1'b1;
    ld = do_ld;
    ld_addr = a0;
    step();
    for (int k = 1; k <= 4; k++) begin
      reb = noise;
      ld = noise;
      ld_addr = 8'h55;
      chk({tag, ".en"}, {31'd0, ram_en}, 32'd1);
      chk({tag, ".addr"}, {24'd0, address},
          {24'd0, a0 + 8'(k - 1)});
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      chk({tag, ".novld"}, {31'd0, valid}, 32'd0);
      chk_ops({tag, ".hold"}, prev[0], prev[1], prev[2], prev[3]);
      step();
    end
    chk({tag, ".drain_en"}, {31'd0, ram_en}, 32'd0);
    chk({tag, ".drain_vld"}, {31'd0, valid}, 32'd0);
    chk({tag, ".drain_busy"}, {31'd0, busy}, 32'd1);
    chk_ops({tag, ".drain_hold"}, prev[0], prev[1], prev[2], prev[3]);
    step();
    reb = 1'b0;
    ld = 1'b0;
    chk({tag, ".vld"}, {31'd0, valid}, 32'd1);
    chk({tag, ".done_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".ptr"}, {24'd0, address}, {24'd0, a0 + 8'd4});
    chk_ops(tag, e1, e2, e3, e4);
    prev[0] = e1;
    prev[1] = e2;
    prev[2] = e3;
    prev[3] = e4;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | i;
    mem[0] = 32'h0001_0005;
    mem[1] = 32'h0000_0007;
    mem[2] = 32'h0003_FFFF;
    mem[3] = 32'h0000_1234;
    mem[4] = 32'h0000_0011;
    mem[5] = 32'h0000_0022;
    mem[6] = 32'h0000_0033;
    mem[7] = 32'h0000_0044;
    mem[8] = 32'hFFFC_0000;
    mem[9] = 32'h1234_5678;
    mem[10] = 32'h0002_ABCD;
    mem[11] = 32'hFFFF_FFFF;
    mem[254] = 32'h0000_0AAA;
    mem[255] = 32'h0000_0BBB;
    for (int i = 0; i < 4; i++) prev[i] = 18'd0;
    dataRAM = 32'd0;
    rst = 1'b1;
    reb = 1'b0;
    ld = 1'b0;
    ld_addr = 8'd0;
    step();
    step();
    chk("rst.en", {31'd0, ram_en}, 32'd0);
    chk("rst.addr", {24'd0, address}, 32'd0);
    chk("rst.vld", {31'd0, valid}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk_ops("rst", 18'd0, 18'd0, 18'd0, 18'd0);
    rst = 1'b0;
    step();

    fetch("t1", 8'd0, 1'b0, 1'b0,
          18'h10005, 18'h00007, 18'h3FFFF, 18'h01234);
    step();
    fetch("t2", 8'd4, 1'b0, 1'b0,
          18'h00011, 18'h00022, 18'h00033, 18'h00044);
    step();
    fetch("t3", 8'd254, 1'b1, 1'b0,
          18'h00AAA, 18'h00BBB, 18'h10005, 18'h00007);
    fetch("t4a", 8'd2, 1'b0, 1'b1,
          18'h3FFFF, 18'h01234, 18'h00011, 18'h00022);
    fetch("t4b", 8'd6, 1'b0, 1'b1,
          18'h00033, 18'h00044, 18'h00000, 18'h05678);
    step();

    reb = 1'b1;
    ld = 1'b1;
    ld_addr = 8'd0;
    step();
    reb = 1'b0;
    ld = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5.en", {31'd0, ram_en}, 32'd0);
    chk("t5.addr", {24'd0, address}, 32'd0);
    chk("t5.busy", {31'd0, busy}, 32'd0);
    chk("t5.vld", {31'd0, valid}, 32'd0);
    chk_ops("t5", 18'd0, 18'd0, 18'd0, 18'd0);
    for (int i = 0; i < 8; i++) begin
      chk("t5.quiet", {30'd0, valid, ram_en}, 32'd0);
      step();
    end
    for (int i = 0; i < 4; i++) prev[i] = 18'd0;

    fetch("t6", 8'd8, 1'b1, 1'b0,
          18'h00000, 18'h05678, 18'h2ABCD, 18'h3FFFF);
    step();
    chk("t6.idle_vld", {31'd0, valid}, 32'd0);
    chk_ops("t6.keep", 18'h00000, 18'h05678, 18'h2ABCD, 18'h3FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, want finish");
    $fatal(1);
  end

endmodule

// File: doc/rb_fetch.md
Name: rb_fetch

Overview:
- Read-back/fetch block: the reading counterpart of the result write-back unit.
- On a start request it reads four consecutive words from the shared result RAM and presents them as four parallel operands (OP1..OP4) to the MAC/multiplier stage.
- Holds a free-running read pointer that advances per word read and can be reloaded.
- Sits between the RAM read port and the compute datapath.

Parameters:
- ADDR_W, 8, RAM address width; the pointer wraps modulo 2^ADDR_W.
- DATA_W, 32, RAM read data width.
- OP_W, 18, operand output width; OP_W <= DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- reb  input  1  read-back start request, sampled each cycle.
- ld  input  1  load the read pointer from ld_addr.
- ld_addr  input  ADDR_W  new read pointer value.
- ram_en  output  1  RAM read enable.
- address  output  ADDR_W  RAM read address.
- dataRAM  input  DATA_W  RAM read data, valid exactly 1 cycle after the ram_en cycle.
- OP1  output  OP_W  word read from the start address.
- OP2  output  OP_W  word read from the start address +1.
- OP3  output  OP_W  word read from the start address +2.
- OP4  output  OP_W  word read from the start address +3.
- valid  output  1  one-cycle pulse: OP1..OP4 are updated and complete.
- busy  output  1  fetch in progress; reb is ignored while high.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, pointer=0, issue and capture counters=0. Outputs: ram_en=0, address=0, valid=0, busy=0, OP1..OP4=0.
- Reset asserted mid-fetch aborts the fetch at once. No valid pulse is produced, and RAM data still in flight is discarded.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - ld=1 loads pointer<=ld_addr.
  - reb=1 -> ISSUE, with issue counter=0.
  - If ld and reb are both high in the same cycle, the fetch starts at ld_addr, not the old pointer.
- ISSUE (4 cycles):
  - ram_en=1; address=pointer.
  - Pointer and issue counter increment every cycle.
  - Leaves for DRAIN after the 4th address is issued.
- DRAIN (1 cycle): ram_en=0; the last word is captured.
- Capture:
  - Each cycle following a ram_en=1 cycle, dataRAM[OP_W-1:0] is written into buffer[capture counter], and the capture counter increments.
  - Upper DATA_W-OP_W bits are dropped: plain truncation, no saturation.
- DONE (1 cycle):
  - OP1..OP4 <= buffer[0..3], all four updated together; valid=1; busy=0.
  - Next state is IDLE. reb=1 in DONE is accepted: next state is ISSUE, giving back-to-back fetches.
- Hold behaviour: OP1..OP4 hold their values until the next DONE. They never show partial fetch data.
- Busy: busy=1 in ISSUE and DRAIN. reb and ld are ignored while busy; ld never corrupts an in-flight fetch.
- Timing: with reb sampled at edge T0, ram_en is high in cycles T0+1..T0+4. valid pulses in cycle T0+6. Start-to-valid latency = 6 cycles; throughput = 1 fetch per 6 cycles.
- Wrap-around: the pointer increments modulo 2^ADDR_W. A fetch starting at 254 reads 254, 255, 0, 1.
- Address output: while ram_en=0, address shows the current pointer; it is don't-care to the RAM.

Test Plan:
1. Reset, preload RAM[0..3]=0x0001_0005, 0x0000_0007, 0x0003_FFFF, 0x0000_1234. Pulse reb -> ram_en high 4 cycles at addresses 0,1,2,3. Valid at T0+6 with OP1=0x10005 (the 18-bit truncation of 0x0001_0005), OP2=0x00007, OP3=0x3FFFF, OP4=0x01234. Pointer ends at 4.
2. Second reb with no ld -> addresses 4..7 read; OP1..OP4 stay at the old values until the new valid pulse.
3. ld=1, ld_addr=254 together with reb -> addresses 254, 255, 0, 1 are issued in that order; OP1..OP4 equal those words.
4. reb held high continuously -> valid every 6 cycles, addresses strictly consecutive. reb and ld pulses during ISSUE/DRAIN have no effect on addresses or pointer.
5. Assert rst during the 3rd ISSUE cycle -> next cycle ram_en=0, address=0, busy=0, OP1..OP4=0. No valid pulse occurs afterwards until a new reb.
6. RAM word 0xFFFC_0000 -> OP equals 0x00000, confirming upper bits are dropped.
